// File: rtl/scan_frame_tx_ctrl.sv
// scan_frame_tx_ctrl: queues scan begin/test/end and encode-trigger events and sends each
// as a sync word (+ encoder payload) over a valid/ready word port.
module scan_frame_tx_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TRIG_CH = 2,
  parameter int PAYLOAD_WORDS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] SYNC_SCAN_BEGIN = 16'h5A51,
  parameter logic [15:0] SYNC_SCAN_TEST = 16'h5A53,
  parameter logic [15:0] SYNC_SCAN_END = 16'h5A50,
  parameter logic [15:0] SYNC_ENCODE_BASE = 16'hECDE,
  localparam int PW = (PAYLOAD_WORDS > 0) ? PAYLOAD_WORDS : 1,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pmt_scan_cmd_sel_i,
  input  logic [3:0]               pmt_scan_cmd_i,
  input  logic [TRIG_CH-1:0]       track_trigger_i,
  input  logic [PW*DATA_WIDTH-1:0] encode_val_i,
  output logic                     tx_valid_o,
  output logic [DATA_WIDTH-1:0]    tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     pmt_start_en_o,
  output logic                     pmt_start_test_en_o,
  output logic [AW:0]              fifo_level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     busy_o
);
  localparam int KW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [KW-1:0] KLAST = KW'(PW - 1);
  localparam logic HAS_PAY = PAYLOAD_WORDS > 0;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD} state_t;
  state_t r_state, w_state_nxt;
  logic r_scan, r_scan_d, r_test;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_level;
  logic [15:0] r_drop;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [DATA_WIDTH-1:0] r_sync_mem [FIFO_DEPTH];
  logic r_enc_mem [FIFO_DEPTH];
  logic [PW-1:0][DATA_WIDTH-1:0] r_pay_mem [FIFO_DEPTH];
  logic w_rise, w_fall, w_ctrl, w_enc_push, w_push, w_pop, w_has_pay, w_unused;
  logic [TRIG_CH-1:0] w_trig;
  logic [2:0] w_ch;
  logic [3:0] w_ntrig, w_drops;
  logic [15:0] w_sync16;
  logic [16:0] w_drop_sum;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_unused = ^pmt_scan_cmd_i[3:2];
  assign w_rise = r_scan & ~r_scan_d;
  assign w_fall = ~r_scan & r_scan_d;
  assign w_ctrl = w_rise | w_fall;
  assign w_trig = r_scan_d ? track_trigger_i : '0;

  always_comb begin
    w_ch = '0;
    w_ntrig = '0;
    for (int i = TRIG_CH - 1; i >= 0; i--) if (w_trig[i]) w_ch = 3'(i);
    for (int i = 0; i < TRIG_CH; i++) w_ntrig = w_ntrig + 4'(w_trig[i]);
  end

  // Encodes keep one slot free so an END can always follow them into the queue.
  assign w_enc_push = ~w_ctrl & (|w_trig) & (r_level < (AW+1)'(FIFO_DEPTH - 1));
  assign w_push = (w_ctrl & (r_level < (AW+1)'(FIFO_DEPTH))) | w_enc_push;
  assign w_drops = w_ntrig - 4'(w_enc_push);
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_drops);
  assign w_sync16 = w_rise ? (r_test ? SYNC_SCAN_TEST : SYNC_SCAN_BEGIN) :
                    w_fall ? SYNC_SCAN_END : SYNC_ENCODE_BASE - 16'(w_ch);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scan <= 1'b0;
      r_scan_d <= 1'b0;
      r_test <= 1'b0;
      r_drop <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
      r_state <= S_IDLE;
      r_k <= '0;
    end else begin
      if (pmt_scan_cmd_sel_i) r_scan <= pmt_scan_cmd_i[0];
      if (pmt_scan_cmd_sel_i & pmt_scan_cmd_i[0]) r_test <= pmt_scan_cmd_i[1];
      r_scan_d <= r_scan;
      r_drop <= w_rise ? '0 : (w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0]);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_state <= w_state_nxt;
      r_k <= w_k_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_sync_mem[r_wr] <= DATA_WIDTH'(w_sync16);
      r_enc_mem[r_wr] <= ~w_ctrl;
      r_pay_mem[r_wr] <= encode_val_i;
    end
  end

  // The head entry stays in the queue while its frame is sent and is retired on the last handshake.
  assign w_has_pay = r_enc_mem[r_rd] & HAS_PAY;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt = r_k;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = (r_level != '0) ? S_SYNC : S_IDLE;
      S_SYNC: if (tx_ready_i) begin
        w_k_nxt = '0;
        w_state_nxt = w_has_pay ? S_PAYLOAD : S_IDLE;
        w_pop = ~w_has_pay;
      end
      S_PAYLOAD: if (tx_ready_i) begin
        w_k_nxt = r_k + KW'(1);
        w_state_nxt = (r_k == KLAST) ? S_IDLE : S_PAYLOAD;
        w_pop = (r_k == KLAST);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_word = r_pay_mem[r_rd][KLAST - r_k];
  assign tx_valid_o = r_state != S_IDLE;
  assign tx_data_o = (r_state == S_SYNC) ? r_sync_mem[r_rd] : (r_state == S_PAYLOAD) ? w_word : '0;
  assign pmt_start_en_o = r_scan_d;
  assign pmt_start_test_en_o = r_scan_d & r_test;
  assign fifo_level_o = r_level;
  assign drop_cnt_o = r_drop;
  assign busy_o = tx_valid_o | (r_level != '0);
endmodule

// File: tb/tb_scan_frame_tx_ctrl.sv
// tb_scan_frame_tx_ctrl: frame-queue reference model checked every cycle, plus directed
// literal checks of latency, ordering, back-pressure, saturation and reset.
module tb_scan_frame_tx_ctrl;
  localparam int DW = 16, TC = 2, PWD = 2, FD = 8;
  logic clk_i = 1'b0, rst_n_i = 1'b0, sel = 1'b0, ready = 1'b0;
  logic [3:0] cmd = '0;
  logic [TC-1:0] trig = '0;
  logic [PWD*DW-1:0] enc = '0;
  logic tx_valid_o, pmt_start_en_o, pmt_start_test_en_o, busy_o;
  logic [DW-1:0] tx_data_o;
  logic [$clog2(FD):0] fifo_level_o;
  logic [15:0] drop_cnt_o;
  int n_vec = 0, n_err = 0;
  logic [15:0] wq[$], log_q[$], exp_q[$];
  int lq[$];
  logic m_scan = 0, m_scan_d = 0, m_test = 0, gap = 0, stall = 0, m_rise, m_fall, m_done;
  logic [15:0] m_drop = 0, held = 0;
  int low_run = 0, m_lvl, m_nt, m_drops, m_ch, m_sum;

  scan_frame_tx_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pmt_scan_cmd_sel_i(sel), .pmt_scan_cmd_i(cmd),
    .track_trigger_i(trig), .encode_val_i(enc), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .tx_ready_i(ready), .pmt_start_en_o(pmt_start_en_o), .pmt_start_test_en_o(pmt_start_test_en_o),
    .fifo_level_o(fifo_level_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model: a queue of pending frames (word stream + per-frame remaining count); level = frames not yet fully sent.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      wq.delete(); lq.delete();
      m_scan = 0; m_scan_d = 0; m_test = 0; m_drop = 0; gap = 0; stall = 0; low_run = 0;
    end else begin
      chk("start_en", pmt_start_en_o, m_scan_d);
      chk("test_en", pmt_start_test_en_o, m_scan_d & m_test);
      chk("level", fifo_level_o, lq.size());
      chk("busy", busy_o, lq.size() != 0);
      chk("drop_cnt", drop_cnt_o, m_drop);
      if (gap) chk("frame_gap", tx_valid_o, 0);
      if (stall) begin
        chk("stall_valid", tx_valid_o, 1);
        chk("stall_data", tx_data_o, held);
      end
      low_run = (!tx_valid_o && lq.size() != 0) ? low_run + 1 : 0;
      if (low_run > 1) chk("start_latency", low_run, 1);
      stall = tx_valid_o && !ready;
      held = tx_data_o;
      m_done = 0;
      if (tx_valid_o && ready) begin
        if (wq.size() == 0) chk("extra_word", tx_valid_o, 0);
        else begin
          chk("word", tx_data_o, wq.pop_front());
          log_q.push_back(tx_data_o);
          lq[0]--;
          m_done = (lq[0] == 0);
        end
      end
      gap = m_done;
      m_lvl = lq.size();
      m_rise = m_scan && !m_scan_d;
      m_fall = !m_scan && m_scan_d;
      m_nt = m_scan_d ? $countones(trig) : 0;
      m_drops = m_nt;
      if (m_rise || m_fall) begin
        if (m_lvl < FD) begin
          wq.push_back(m_rise ? (m_test ? 16'h5A53 : 16'h5A51) : 16'h5A50);
          lq.push_back(1);
        end
      end else if (m_nt > 0 && m_lvl < FD - 1) begin
        for (int k = TC - 1; k >= 0; k--) if (trig[k]) m_ch = k;
        wq.push_back(16'hECDE - 16'(m_ch));
        for (int k = PWD - 1; k >= 0; k--) wq.push_back(enc[k*DW +: DW]);
        lq.push_back(PWD + 1);
        m_drops = m_nt - 1;
      end
      if (m_done) void'(lq.pop_front());
      m_sum = int'(m_drop) + m_drops;
      m_drop = m_rise ? 16'h0 : (m_sum > 65535 ? 16'hFFFF : 16'(m_sum));
      m_scan_d = m_scan;
      if (sel) m_scan = cmd[0];
      if (sel && cmd[0]) m_test = cmd[1];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [3:0] c);
    sel = 1; cmd = c; cyc(1); sel = 0;
  endtask

  task automatic fire(input logic [TC-1:0] m, input logic [PWD*DW-1:0] v);
    trig = m; enc = v; cyc(1); trig = '0;
  endtask

  task automatic drain();
    int t = 0;
    cyc(2);
    while ((busy_o || tx_valid_o) && t < 400) begin cyc(1); t++; end
    if (t >= 400) chk("drain_timeout", busy_o, 0);
  endtask

  task automatic ex(input logic [15:0] w);
    exp_q.push_back(w);
  endtask

  task automatic cmp_log();
    chk("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) chk("log_word", log_q[i], exp_q[i]);
    log_q.delete(); exp_q.delete();
  endtask

  initial begin
    cyc(2);
    chk("rst_valid", tx_valid_o, 0); chk("rst_data", tx_data_o, 0); chk("rst_level", fifo_level_o, 0);
    chk("rst_drop", drop_cnt_o, 0); chk("rst_busy", busy_o, 0); chk("rst_pmt", pmt_start_en_o, 0);
    rst_n_i = 1; ready = 1; cyc(1);
    // begin, three ch0 encodes, end
    log_q.delete();
    strobe(4'b0001);
    chk("pmt_c1", pmt_start_en_o, 0);
    cyc(1); chk("pmt_c2", pmt_start_en_o, 1); chk("valid_c2", tx_valid_o, 0);
    cyc(1); chk("valid_c3", tx_valid_o, 1); chk("data_c3", tx_data_o, 16'h5A51);
    fire(2'b01, 32'h0001_0002); cyc(3);
    fire(2'b01, 32'h0003_0004);
    fire(2'b01, 32'h0005_0006);
    strobe(4'b0000); drain();
    ex(16'h5A51);
    for (int i = 0; i < 3; i++) begin ex(16'hECDE); ex(16'(2*i+1)); ex(16'(2*i+2)); end
    ex(16'h5A50); cmp_log();
    chk("s1_drop", drop_cnt_o, 0);
    // test-mode begin
    strobe(4'b0011); cyc(1);
    chk("test_en_c2", pmt_start_test_en_o, 1);
    cmd = '0; cyc(5);
    chk("test_en_held", pmt_start_test_en_o, 1);
    strobe(4'b0000); drain();
    ex(16'h5A53); ex(16'h5A50); cmp_log();
    // simultaneous triggers, then ch1 alone
    strobe(4'b0001); cyc(1);
    fire(2'b11, 32'hAAAA_BBBB); cyc(1);
    fire(2'b10, 32'hCCCC_DDDD);
    strobe(4'b0000); drain();
    ex(16'h5A51); ex(16'hECDE); ex(16'hAAAA); ex(16'hBBBB); ex(16'hECDD); ex(16'hCCCC); ex(16'hDDDD); ex(16'h5A50);
    cmp_log();
    chk("dual_drop", drop_cnt_o, 1);
    // back-pressure: queue fills, END still fits in the reserved slot
    ready = 0;
    strobe(4'b0001); cyc(1);
    for (int i = 0; i < 10; i++) fire(2'b01, {16'(i + 1), 16'(i + 16)});
    chk("bp_level", fifo_level_o, 7); chk("bp_drop", drop_cnt_o, 4);
    strobe(4'b0000); cyc(1);
    chk("bp_level_end", fifo_level_o, 8);
    ready = 1; drain();
    ex(16'h5A51);
    for (int i = 0; i < 6; i++) begin ex(16'hECDE); ex(16'(i + 1)); ex(16'(i + 16)); end
    ex(16'h5A50); cmp_log();
    // randomized traffic with throttled ready
    for (int c = 0; c < 3000; c++) begin
      ready = (c < 1500) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 40) == 0);
      cmd = 4'($urandom);
      trig = ($urandom_range(0, 3) == 0) ? TC'($urandom) : '0;
      enc = $urandom;
      cyc(1);
    end
    sel = 0; trig = '0; ready = 1;
    strobe(4'b0000); drain();
    log_q.delete();
    // drop counter saturation and clear on next begin
    ready = 0;
    strobe(4'b0001); cyc(1);
    trig = 2'b11; enc = 32'h1234_5678; cyc(33000); trig = '0;
    chk("sat_drop", drop_cnt_o, 16'hFFFF); chk("sat_level", fifo_level_o, 7);
    strobe(4'b0000); ready = 1; drain();
    strobe(4'b0001); cyc(1);
    chk("drop_clear", drop_cnt_o, 0);
    drain(); log_q.delete();
    // trigger latency, then reset in the middle of the payload
    fire(2'b01, 32'h9999_8888);
    chk("trig_t1_valid", tx_valid_o, 0);
    cyc(1); chk("trig_t2_valid", tx_valid_o, 1); chk("trig_t2_data", tx_data_o, 16'hECDE);
    cyc(1); chk("pay_data", tx_data_o, 16'h9999);
    rst_n_i = 0; #1;
    chk("arst_valid", tx_valid_o, 0); chk("arst_level", fifo_level_o, 0);
    chk("arst_busy", busy_o, 0); chk("arst_pmt", pmt_start_en_o, 0);
    cyc(2); rst_n_i = 1; cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
